// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared types for the hazard / forwarding controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_LOP = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    LOP_IDLE = 2'd0,
    LOP_RUN  = 2'd1,
    LOP_DONE = 2'd2
  } lop_state_e;

  localparam int unsigned REG_X0 = 0;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_scoreboard_fwd_select.sv
// ============================================================================
// fwd_select : priority bypass mux for one EX source operand
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fwd_select
  import core_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic            lop_done_i,
  input  logic [RA_W-1:0] lop_rd_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            mem_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            wb_we_i,
  output fwd_sel_e        sel_o
);

  // The long-op result beats MEM and WB: it is the youngest value for that rd.
  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != RA_W'(REG_X0)) begin
      if (lop_done_i && (lop_rd_i == rs_i))
        sel_o = FWD_LOP;
      else if (mem_we_i && (mem_rd_i == rs_i))
        sel_o = FWD_MEM;
      else if (wb_we_i && (wb_rd_i == rs_i))
        sel_o = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_scoreboard.sv
// ============================================================================
// hazard_fwd_scoreboard : EX bypass selects, load-use and long-op interlock.
// Long-op scoreboard built only when HAZ_LOP_SCOREBOARD_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int RA_W    = 5,
  parameter int LAT_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid_i,
  input  logic [NUM_SRC-1:0][RA_W-1:0]  id_rs_i,
  input  logic                          id_lop_i,
  input  logic [NUM_SRC-1:0][RA_W-1:0]  ex_rs_i,
  input  logic [RA_W-1:0]               ex_rd_i,
  input  logic [RA_W-1:0]               mem_rd_i,
  input  logic [RA_W-1:0]               wb_rd_i,
  input  logic                          ex_regwrite_i,
  input  logic                          mem_regwrite_i,
  input  logic                          wb_regwrite_i,
  input  logic                          ex_memread_i,
  input  logic                          lop_issue_i,
  input  logic [LAT_W-1:0]              lop_lat_i,
  output logic [NUM_SRC-1:0][1:0]       fwd_sel_o,
  output logic                          stall_o,
  output logic                          bubble_o,
  output logic                          lop_done_o,
  output logic [RA_W-1:0]               lop_rd_o,
  output logic                          busy_o,
  output logic                          err_o
);

  logic            ld_use_stall;
  logic            sb_stall;
  logic            lop_done;
  logic [RA_W-1:0] lop_rd;

  always_comb begin
    ld_use_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (id_rs_i[i] == ex_rd_i) ld_use_stall = 1'b1;
    ld_use_stall = ld_use_stall & ex_memread_i & ex_regwrite_i &
                   (ex_rd_i != RA_W'(REG_X0));
  end

`ifdef HAZ_LOP_SCOREBOARD_EN
  lop_state_e       state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [RA_W-1:0]  rd_q;
  logic             err_q;
  logic [LAT_W-1:0] issue_cnt;
  logic             rd_nz;
  logic             id_hit;

  // L=0 is treated as L=1, so the counter never underflows.
  assign issue_cnt = (lop_lat_i == '0) ? '0 : lop_lat_i - LAT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOP_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        LOP_IDLE, LOP_DONE: begin
          if (lop_issue_i) begin
            rd_q    <= ex_rd_i;
            cnt_q   <= issue_cnt;
            state_q <= (issue_cnt == '0) ? LOP_DONE : LOP_RUN;
          end else begin
            state_q <= LOP_IDLE;
          end
        end
        LOP_RUN: begin
          if (lop_issue_i) err_q <= 1'b1;
          cnt_q <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) state_q <= LOP_DONE;
        end
        default: state_q <= LOP_IDLE;
      endcase
    end
  end

  assign rd_nz = (rd_q != RA_W'(REG_X0));

  always_comb begin
    id_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (id_rs_i[i] == rd_q) id_hit = 1'b1;
  end

  // In DONE the result is forwarded, so only RUN interlocks.
  assign sb_stall = (state_q == LOP_RUN) &
                    ((rd_nz & id_hit) |
                     (rd_nz & ex_regwrite_i & (ex_rd_i == rd_q)) |
                     id_lop_i);
  assign lop_done = (state_q == LOP_DONE);
  assign lop_rd   = rd_q;
  assign busy_o   = (state_q != LOP_IDLE);
  assign err_o    = err_q;
`else
  logic lop_unused;
  assign lop_unused = ^{clk, id_lop_i, lop_issue_i, lop_lat_i};
  assign sb_stall   = 1'b0;
  assign lop_done   = 1'b0;
  assign lop_rd     = '0;
  assign busy_o     = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign lop_done_o = lop_done;
  assign lop_rd_o   = lop_rd;
  assign stall_o    = rst_n & id_valid_i & (ld_use_stall | sb_stall);
  assign bubble_o   = stall_o;

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_sel_e src_sel;
      fwd_select #(.RA_W(RA_W)) u_fwd_select (
        .rs_i       (ex_rs_i[g]),
        .lop_done_i (lop_done),
        .lop_rd_i   (lop_rd),
        .mem_rd_i   (mem_rd_i),
        .mem_we_i   (mem_regwrite_i),
        .wb_rd_i    (wb_rd_i),
        .wb_we_i    (wb_regwrite_i),
        .sel_o      (src_sel)
      );
      assign fwd_sel_o[g] = rst_n ? src_sel : FWD_RF;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_scoreboard.sv
// ============================================================================
// tb_hazard_fwd_scoreboard : vector table, directed sequences and random run
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_scoreboard;
  import core_pkg::*;

  localparam int NS = 2;
  localparam int RW = 5;
  localparam int LW = 4;
`ifdef HAZ_LOP_SCOREBOARD_EN
  localparam bit LOP_EN = 1'b1;
`else
  localparam bit LOP_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  id_valid;
  logic [NS-1:0][RW-1:0] id_rs;
  logic                  id_lop;
  logic [NS-1:0][RW-1:0] ex_rs;
  logic [RW-1:0]         ex_rd, mem_rd, wb_rd;
  logic                  ex_rw, mem_rw, wb_rw, ex_mr;
  logic                  lop_issue;
  logic [LW-1:0]         lop_lat;
  logic [NS-1:0][1:0]    fwd_sel;
  logic                  stall, bubble, lop_done, busy, err;
  logic [RW-1:0]         lop_rd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference scoreboard: an op is pending until the cycle its result is due.
  bit            m_pend = 1'b0;
  int            m_due = 0;
  logic [RW-1:0] m_rd = '0;
  bit            m_err = 1'b0;

  hazard_fwd_scoreboard #(.NUM_SRC(NS), .RA_W(RW), .LAT_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_lop_i(id_lop), .ex_rs_i(ex_rs), .ex_rd_i(ex_rd), .mem_rd_i(mem_rd),
    .wb_rd_i(wb_rd), .ex_regwrite_i(ex_rw), .mem_regwrite_i(mem_rw),
    .wb_regwrite_i(wb_rw), .ex_memread_i(ex_mr), .lop_issue_i(lop_issue),
    .lop_lat_i(lop_lat), .fwd_sel_o(fwd_sel), .stall_o(stall),
    .bubble_o(bubble), .lop_done_o(lop_done), .lop_rd_o(lop_rd),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] ers0, ers1, mrd, wrd, erd, irs0, irs1;
    logic          mwe, wwe, ewe, emr, ival;
    logic [1:0]    sel0, sel1;
    logic          stl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_run();
    return LOP_EN && m_pend && (cyc < m_due);
  endfunction

  function automatic bit m_done();
    return LOP_EN && m_pend && (cyc == m_due);
  endfunction

  function automatic logic [1:0] exp_sel(input int i);
    if (!rst_n || ex_rs[i] == 0) return 2'd0;
    if (m_done() && m_rd == ex_rs[i]) return 2'd3;
    if (mem_rw && mem_rd == ex_rs[i]) return 2'd2;
    if (wb_rw && wb_rd == ex_rs[i]) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic exp_stall();
    bit lu, sb, hit_ex, hit_lop;
    hit_ex = 0; hit_lop = 0;
    for (int i = 0; i < NS; i++) begin
      if (id_rs[i] == ex_rd) hit_ex = 1;
      if (id_rs[i] == m_rd) hit_lop = 1;
    end
    lu = ex_mr && ex_rw && ex_rd != 0 && hit_ex;
    sb = m_run() && ((m_rd != 0 && hit_lop) || (m_rd != 0 && ex_rw && ex_rd == m_rd) || id_lop);
    return rst_n && id_valid && (lu || sb);
  endfunction

  task automatic check_all();
    for (int i = 0; i < NS; i++) chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i]), 32'(exp_sel(i)));
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("bubble", 32'(bubble), 32'(exp_stall()));
    chk("lop_done", 32'(lop_done), 32'(rst_n && m_done()));
    chk("lop_rd", 32'(lop_rd), LOP_EN ? 32'(m_rd) : 32'd0);
    chk("busy", 32'(busy), 32'(LOP_EN && m_pend));
    chk("err", 32'(err), 32'(LOP_EN && m_err));
  endtask

  task automatic model_reset();
    m_pend = 0; m_due = 0; m_rd = '0; m_err = 0;
  endtask

  task automatic model_edge();
    int l;
    if (!rst_n) model_reset();
    else if (LOP_EN) begin
      if (lop_issue) begin
        if (m_run()) m_err = 1;
        else begin
          l = (lop_lat == 0) ? 1 : int'(lop_lat);
          m_pend = 1; m_due = cyc + l; m_rd = ex_rd;
        end
      end else if (m_done()) m_pend = 0;
    end
    cyc++;
  endtask

  // Inputs are set just after the falling edge; outputs checked 1ns later.
  task automatic step(input bit full);
    #1;
    if (full) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs = '0; id_lop = 0; ex_rs = '0; ex_rd = '0; mem_rd = '0;
    wb_rd = '0; ex_rw = 0; mem_rw = 0; wb_rw = 0; ex_mr = 0; lop_issue = 0; lop_lat = '0;
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{5, 3, 5, 5, 0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 0};
    vt[1] = '{5, 3, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0};
    vt[3] = '{2, 6, 6, 6, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0};
    vt[4] = '{4, 4, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 0};
    vt[5] = '{0, 0, 0, 0, 7, 1, 7, 0, 0, 1, 1, 1, 2'b00, 2'b00, 1};
    vt[6] = '{0, 0, 0, 0, 7, 1, 7, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0};
    vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0};
    vt[8] = '{0, 0, 0, 0, 7, 7, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0};
    vt[9] = '{0, 0, 0, 0, 7, 7, 2, 0, 0, 1, 1, 1, 2'b00, 2'b00, 1};

    idle_inputs();
    ex_rs[0] = 5; mem_rd = 5; mem_rw = 1;
    id_valid = 1; ex_rd = 5; id_rs[0] = 5; ex_rw = 1; ex_mr = 1;
    @(negedge clk);
    #1;
    chk("rst_fwd0", 32'(fwd_sel[0]), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_lop_rd", 32'(lop_rd), 0);
    @(posedge clk); model_edge(); @(negedge clk);
    rst_n = 1;
    idle_inputs();

    for (int k = 0; k < 10; k++) begin
      ex_rs[0] = vt[k].ers0; ex_rs[1] = vt[k].ers1; mem_rd = vt[k].mrd; wb_rd = vt[k].wrd;
      ex_rd = vt[k].erd; id_rs[0] = vt[k].irs0; id_rs[1] = vt[k].irs1;
      mem_rw = vt[k].mwe; wb_rw = vt[k].wwe; ex_rw = vt[k].ewe; ex_mr = vt[k].emr;
      id_valid = vt[k].ival;
      #1;
      chk($sformatf("tbl%0d_sel0", k), 32'(fwd_sel[0]), 32'(vt[k].sel0));
      chk($sformatf("tbl%0d_sel1", k), 32'(fwd_sel[1]), 32'(vt[k].sel1));
      chk($sformatf("tbl%0d_stall", k), 32'(stall), 32'(vt[k].stl));
      chk($sformatf("tbl%0d_bubble", k), 32'(bubble), 32'(vt[k].stl));
      step(0);
    end

    // Load-use: one stall cycle, cleared once the load reaches MEM.
    idle_inputs();
    id_valid = 1; id_rs[1] = 7; ex_rd = 7; ex_rw = 1; ex_mr = 1;
    #1; chk("lu_stall", 32'(stall), 1); chk("lu_bubble", 32'(bubble), 1);
    step(1);
    ex_rd = 3; ex_mr = 0; mem_rd = 7; mem_rw = 1;
    #1; chk("lu_release", 32'(stall), 0);
    step(1);

    // Long op rd=9, L=4.
    idle_inputs();
    lop_issue = 1; lop_lat = 4; ex_rd = 9; ex_rw = 1;
    step(1);
    idle_inputs();
    id_valid = 1; id_rs[0] = 9; ex_rs[0] = 9; wb_rd = 9; wb_rw = 1;
    for (int k = 1; k <= 3; k++) begin
      #1; chk($sformatf("lop_stall_t%0d", k), 32'(stall), 32'(LOP_EN));
      step(1);
    end
    #1;
    chk("lop_done_t4", 32'(lop_done), 32'(LOP_EN));
    chk("lop_sel_t4", 32'(fwd_sel[0]), LOP_EN ? 32'd3 : 32'd1);
    chk("lop_nostall_t4", 32'(stall), 0);
    step(1);
    #1; chk("lop_idle_t5", 32'(busy), 0);
    step(1);

    // Illegal issue in RUN, then a legal re-issue in DONE.
    idle_inputs();
    lop_issue = 1; lop_lat = 3; ex_rd = 4; step(1);
    lop_issue = 1; lop_lat = 5; ex_rd = 6; step(1);
    lop_issue = 0; step(1);
    #1; chk("done_before_reissue", 32'(lop_done), 32'(LOP_EN));
    lop_issue = 1; lop_lat = 2; ex_rd = 11; step(1);
    lop_issue = 0;
    #1;
    chk("reissue_rd", 32'(lop_rd), LOP_EN ? 32'd11 : 32'd0);
    chk("err_sticky", 32'(err), 32'(LOP_EN));
    step(1);
    step(1);

    // Asynchronous reset in the middle of a long op.
    idle_inputs();
    lop_issue = 1; lop_lat = 10; ex_rd = 12; step(1);
    idle_inputs();
    lop_issue = 1; lop_lat = 2; ex_rd = 13; step(1);
    lop_issue = 0; id_valid = 1; id_rs[0] = 12; step(1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_err", 32'(err), 0);
    model_reset();
    @(posedge clk); model_edge(); @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      #1; chk("arst_no_done", 32'(lop_done), 0);
      step(1);
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      id_valid = 1'($urandom_range(0, 1));
      id_lop = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NS; i++) begin
        id_rs[i] = RW'($urandom_range(0, 3));
        ex_rs[i] = RW'($urandom_range(0, 3));
      end
      ex_rd = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd = RW'($urandom_range(0, 3));
      ex_rw = 1'($urandom_range(0, 1)); mem_rw = 1'($urandom_range(0, 1));
      wb_rw = 1'($urandom_range(0, 1)); ex_mr = ($urandom_range(0, 3) == 0);
      lop_issue = ($urandom_range(0, 5) == 0);
      lop_lat = LW'($urandom_range(0, 6));
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_fwd_scoreboard.md
# hazard_fwd_scoreboard

Parametrised hazard and forwarding controller for the 5-stage core, with a small scoreboard for one outstanding multi-cycle operation (divider/multiplier). It sits beside the ID/EX pipeline registers. Each cycle it produces per-source bypass selects for EX and a load-use or long-op stall for IF/ID. It supersedes the purely combinational two-source forwarding logic: source count and long-op latency are configurable, and it adds load-use interlock plus long-op tracking.

## Interface
- `NUM_SRC`, default 2: register sources per instruction (2 or 3).
- `RA_W`, default 5: register address width.
- `LAT_W`, default 4: width of the long-op latency field; latencies 1..2^LAT_W-1.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_rs_i` in NUM_SRC×RA_W: ID source addresses.
- `id_lop_i` in 1: ID instruction is a long op.
- `ex_rs_i` in NUM_SRC×RA_W: ID/EX source addresses, used for forwarding.
- `ex_rd_i`, `mem_rd_i`, `wb_rd_i` in RA_W each: destination addresses in EX, MEM and WB.
- `ex_regwrite_i`, `mem_regwrite_i`, `wb_regwrite_i` in 1 each: matching write enables.
- `ex_memread_i` in 1: EX instruction is a load.
- `lop_issue_i` in 1: long op launched from EX this cycle.
- `lop_lat_i` in LAT_W: its latency L.
- `fwd_sel_o` out NUM_SRC×2: per-source select. 00 = regfile, 01 = WB, 10 = MEM, 11 = long-op result.
- `stall_o` out 1: hold PC and IF/ID.
- `bubble_o` out 1: insert a NOP into ID/EX; always equal to `stall_o`.
- `lop_done_o` out 1: long-op result valid this cycle.
- `lop_rd_o` out RA_W: destination of the long op.
- `busy_o` out 1: long op outstanding.
- `err_o` out 1: sticky flag, set on an illegal issue.

## Operation
Forwarding (combinational, per source i):
- Sources with address x0 never forward.
- Priority order:
  - `lop_done_o` and `lop_rd_o == ex_rs[i]` → 11.
  - MEM match with `mem_regwrite_i` → 10.
  - WB match with `wb_regwrite_i` → 01.
  - Otherwise 00.

Load-use stall:
- Condition: `id_valid_i & ex_memread_i & ex_regwrite_i`, `ex_rd_i != 0`, and `ex_rd_i` equals any `id_rs_i`.

Scoreboard FSM, states IDLE, RUN, DONE:
- IDLE: on `lop_issue_i`, latch rd = `ex_rd_i` and cnt = max(L,1)−1.
  - cnt = 0 → DONE.
  - cnt > 0 → RUN.
- RUN: cnt decrements each cycle; when cnt is 1, the next state is DONE.
- DONE: `lop_done_o` is high for exactly one cycle.
  - A simultaneous `lop_issue_i` is accepted and the new op replaces the old one.
  - Otherwise → IDLE.
- `busy_o` = state ≠ IDLE.

Scoreboard stall (state RUN only; in DONE the result is forwarded instead):
- An `id_rs_i` equals rd (rd ≠ 0).
- `ex_rd_i` equals rd with `ex_regwrite_i` (WAW hazard).
- `id_lop_i` is high (structural hazard).

Other rules:
- `stall_o` = load-use OR scoreboard stall, gated by `id_valid_i`.
- `lop_issue_i` in RUN is illegal: it is ignored and sets `err_o`.
- A long op with rd = x0 runs normally but never stalls or forwards.

## Timing
- All select and stall outputs are combinational from the inputs and registered state; no added latency.
- An op issued at edge t with latency L raises `lop_done_o` in cycle t+L, i.e. the cycle after edge t+L−1 (L=0 behaves as L=1).
- `lop_done_o` in the same cycle as a WB write to the same rd: the long-op result (11) wins.
- Reset, asynchronous at any point including mid-operation:
  - State → IDLE, cnt = 0, rd = 0, `err_o` = 0.
  - All outputs are 0 while `rst_n` is low.
  - An in-flight op is discarded.

## Configuration
- `HAZ_LOP_SCOREBOARD_EN` defined: scoreboard FSM, 11 select and `lop_*`/`busy_o`/`err_o` behaviour as above.
- Macro undefined:
  - No FSM is built.
  - `lop_*` inputs and `id_lop_i` are ignored.
  - `lop_done_o`, `lop_rd_o`, `busy_o` and `err_o` are tied to 0.
  - Selects never produce 11; stall is load-use only.

## Structure
- Shared package `core_pkg`:
  - `fwd_sel_e` (FWD_RF, FWD_WB, FWD_MEM, FWD_LOP).
  - `lop_state_e`.
  - Register x0 constant.
- One sub-module, `fwd_select`: priority mux for one source. It is instantiated NUM_SRC times via a generate loop.

## Test plan
- `ex_rs`=5, MEM rd=5 and WB rd=5, both regwrite → select 10. Drop MEM regwrite → 01.
- `ex_rs`=0, MEM rd=0 with regwrite → select 00.
- EX load with rd=7, ID rs2=7, `id_valid_i`=1 → `stall_o` = `bubble_o` = 1 for exactly one cycle, then 0 once the load moves to MEM.
- Issue rd=9 with L=4 at edge t, ID rs1=9 → stall in cycles t+1..t+3; `lop_done_o`=1 with select 11 in cycle t+4; `busy_o`=0 at t+5.
- Issue in RUN → ignored and `err_o` set. Issue in the DONE cycle → accepted, new rd latched.
- Assert `rst_n` low mid-RUN → `busy_o`, `stall_o` and `err_o` are 0 asynchronously, and no `lop_done_o` follows.
